// File: rtl/i_ddr_word_rx_pkg.sv
// i_ddr_word_rx_pkg: shared types and constants for the DDR word receiver.
//   state_e      : alignment FSM states (HUNT, CONFIRM, LOCKED)
//   offset_e     : latched bit offset of the word boundary within a pair
//   SYNC_DEFAULT : default alignment pattern
package i_ddr_word_rx_pkg;
   typedef enum logic [1:0] {HUNT, CONFIRM, LOCKED} state_e;
   typedef enum logic {OFF0, OFF1} offset_e;
   localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
endpackage

// File: rtl/I_BUF.sv
// I_BUF: behavioural model of the input pad buffer.
//   I  : pad input
//   EN : buffer enable (output low when disabled)
//   O  : buffered signal to fabric
module I_BUF (
   input  logic I,
   input  logic EN,
   output logic O
);
   assign O = EN & I;
endmodule

// File: rtl/I_DDR.sv
// I_DDR: behavioural model of the input DDR capture cell.
//   D : data from I_BUF
//   R : asynchronous active-low reset
//   E : capture enable; low freezes both edge captures and Q
//   C : clock
//   Q : captured pair, Q[0] = rising-edge (earlier) bit, Q[1] = falling-edge (later) bit
module I_DDR (
   input  logic       D,
   input  logic       R,
   input  logic       E,
   input  logic       C,
   output logic [1:0] Q
);
   logic r_q, f_q;
   // The pair is re-timed onto the rising edge after both halves are captured.
   always_ff @(posedge C or negedge R)
      if (!R) begin
         r_q <= 1'b0;
         Q   <= 2'b00;
      end else if (E) begin
         r_q <= D;
         Q   <= {f_q, r_q};
      end
   always_ff @(negedge C or negedge R)
      if (!R) f_q <= 1'b0;
      else if (E) f_q <= D;
endmodule

// File: rtl/rx_word_fifo.sv
// rx_word_fifo: 2-entry FIFO for assembled words; flush has priority over push/pop.
//   clk_buf_i, reset_n_buf : clock, asynchronous active-low reset
//   flush_i                : empties the buffer
//   push_i / data_i        : write request and data (ignored when full and not popping)
//   pop_i                  : read request (ignored when empty)
//   data_o                 : head entry
//   full_o / empty_o       : occupancy flags
module rx_word_fifo #(
   parameter int W = 8
) (
   input  logic         clk_buf_i,
   input  logic         reset_n_buf,
   input  logic         flush_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] data_i,
   output logic [W-1:0] data_o,
   output logic         full_o,
   output logic         empty_o
);
   logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
   logic [1:0]   cnt_q, cnt_d, pos;
   logic         do_pop, do_push;
   always_comb begin
      do_pop  = pop_i && cnt_q != 2'd0;
      do_push = push_i && (cnt_q != 2'd2 || do_pop);
      // Entries shift toward the head on pop; a push lands behind what remains.
      pos     = cnt_q - {1'b0, do_pop};
      e0_d    = do_pop ? e1_q : e0_q;
      e1_d    = e1_q;
      if (do_push) begin
         if (pos == 2'd0) e0_d = data_i;
         else e1_d = data_i;
      end
      cnt_d   = cnt_q - {1'b0, do_pop} + {1'b0, do_push};
      if (flush_i) begin
         e0_d  = '0;
         e1_d  = '0;
         cnt_d = '0;
      end
   end
   always_ff @(posedge clk_buf_i or negedge reset_n_buf)
      if (!reset_n_buf) begin
         e0_q  <= '0;
         e1_q  <= '0;
         cnt_q <= '0;
      end else begin
         e0_q  <= e0_d;
         e1_q  <= e1_d;
         cnt_q <= cnt_d;
      end
   assign data_o  = e0_q;
   assign full_o  = cnt_q == 2'd2;
   assign empty_o = cnt_q == 2'd0;
endmodule

// File: rtl/i_ddr_word_rx.sv
// i_ddr_word_rx: DDR pad receiver; hunts for a sync word, locks alignment and
// delivers WORD_W-bit words through a 2-entry valid/ready buffer.
//   clk_buf_i    : clock (already through CLK_BUF)
//   reset_n_buf  : asynchronous active-low reset
//   data_i       : DDR pad input (I_BUF -> I_DDR)
//   enable_i     : capture enable; low freezes capture, alignment and assembly
//   realign_i    : one-cycle pulse forcing a re-hunt and buffer flush
//   word_o       : assembled word, MSB first in time
//   word_valid_o : word_o valid; word_ready_i accepts
//   locked_o     : alignment achieved
//   overflow_o   : sticky, a completed word was dropped on a full buffer
// Build option: I_DDR_WORD_RX_IDLE_STRIP_EN drops SYNC_WORD fill words while locked.
module i_ddr_word_rx
   import i_ddr_word_rx_pkg::*;
#(
   parameter int                WORD_W    = 8,
   parameter logic [WORD_W-1:0] SYNC_WORD = WORD_W'(SYNC_DEFAULT),
   parameter int                LOCK_CNT  = 3
) (
   input  logic              clk_buf_i,
   input  logic              reset_n_buf,
   input  logic              data_i,
   input  logic              enable_i,
   input  logic              realign_i,
   output logic [WORD_W-1:0] word_o,
   output logic              word_valid_o,
   input  logic              word_ready_i,
   output logic              locked_o,
   output logic              overflow_o
);
   localparam int PAIRS = WORD_W / 2;
   localparam int CW    = $clog2(PAIRS);

   logic              pad_buf;
   logic [1:0]        q_ddr;
   logic [WORD_W+1:0] h_q, h_d;
   logic [WORD_W-1:0] win0, win1, win_sel, pword_q, pword_d;
   state_e            state_q, state_d;
   offset_e           off_q, off_d;
   logic [CW-1:0]     pcnt_q, pcnt_d;
   logic [2:0]        mcnt_q, mcnt_d;
   logic              push_q, push_d, locked_q, ovf_q, ovf_d, bnd, keep, full, empty;

   I_BUF u_ibuf (.I(data_i), .EN(1'b1), .O(pad_buf));
   I_DDR u_iddr (.D(pad_buf), .R(reset_n_buf), .E(enable_i), .C(clk_buf_i), .Q(q_ddr));

   // Windows are taken from the history including the pair consumed this cycle.
   assign h_d     = enable_i ? {h_q[WORD_W-1:0], q_ddr[0], q_ddr[1]} : h_q;
   assign win0    = h_d[WORD_W-1:0];
   assign win1    = h_d[WORD_W:1];
   assign win_sel = (off_q == OFF1) ? win1 : win0;
   assign bnd     = pcnt_q == CW'(PAIRS - 1);

`ifdef I_DDR_WORD_RX_IDLE_STRIP_EN
   assign keep = win_sel != SYNC_WORD;
`else
   assign keep = 1'b1;
`endif

   always_comb begin
      state_d = state_q;
      off_d   = off_q;
      pcnt_d  = pcnt_q;
      mcnt_d  = mcnt_q;
      push_d  = 1'b0;
      pword_d = pword_q;
      if (realign_i) begin
         state_d = HUNT;
         pcnt_d  = '0;
         mcnt_d  = '0;
      end else if (enable_i) begin
         pcnt_d = (state_q == HUNT || bnd) ? '0 : pcnt_q + 1'b1;
         case (state_q)
            HUNT:
               if (win0 == SYNC_WORD || win1 == SYNC_WORD) begin
                  off_d   = (win0 == SYNC_WORD) ? OFF0 : OFF1;
                  mcnt_d  = 3'd1;
                  state_d = (LOCK_CNT == 1) ? LOCKED : CONFIRM;
               end
            CONFIRM:
               if (bnd) begin
                  if (win_sel == SYNC_WORD) begin
                     mcnt_d = mcnt_q + 3'd1;
                     if (mcnt_d == 3'(LOCK_CNT)) state_d = LOCKED;
                  end else begin
                     state_d = HUNT;
                     mcnt_d  = '0;
                  end
               end
            LOCKED:
               if (bnd) begin
                  pword_d = win_sel;
                  push_d  = keep;
               end
            default: state_d = HUNT;
         endcase
      end
   end

   // A push that finds the buffer full with no pop loses the word.
   assign ovf_d = !realign_i && (ovf_q || (push_q && full && !word_ready_i));

   always_ff @(posedge clk_buf_i or negedge reset_n_buf)
      if (!reset_n_buf) begin
         h_q      <= '0;
         state_q  <= HUNT;
         off_q    <= OFF0;
         pcnt_q   <= '0;
         mcnt_q   <= '0;
         push_q   <= 1'b0;
         pword_q  <= '0;
         locked_q <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         h_q      <= h_d;
         state_q  <= state_d;
         off_q    <= off_d;
         pcnt_q   <= pcnt_d;
         mcnt_q   <= mcnt_d;
         push_q   <= push_d;
         pword_q  <= pword_d;
         locked_q <= state_d == LOCKED;
         ovf_q    <= ovf_d;
      end

   rx_word_fifo #(.W(WORD_W)) u_fifo (
      .clk_buf_i  (clk_buf_i),
      .reset_n_buf(reset_n_buf),
      .flush_i    (realign_i),
      .push_i     (push_q),
      .pop_i      (word_ready_i),
      .data_i     (pword_q),
      .data_o     (word_o),
      .full_o     (full),
      .empty_o    (empty)
   );

   assign word_valid_o = !empty;
   assign locked_o     = locked_q;
   assign overflow_o   = ovf_q;
endmodule

// File: tb/tb_i_ddr_word_rx.sv
// tb_i_ddr_word_rx: self-checking bench for i_ddr_word_rx against a bit-stream reference model.
module tb_i_ddr_word_rx;
   localparam int         W    = 8;
   localparam logic [7:0] SYNC = 8'hA5;
   localparam int         LC   = 3;
`ifdef I_DDR_WORD_RX_IDLE_STRIP_EN
   localparam bit STRIP = 1'b1;
`else
   localparam bit STRIP = 1'b0;
`endif

   logic         clk_buf_i = 1'b0, reset_n_buf = 1'b0, data_i = 1'b0;
   logic         enable_i = 1'b0, realign_i = 1'b0, word_ready_i = 1'b0;
   logic [W-1:0] word_o;
   logic         word_valid_o, locked_o, overflow_o;
   int           checks = 0, errors = 0;

   bit           bits[$];
   bit           txq[$];
   logic [W-1:0] exp_q[$];
   int           m_st, m_off, m_m, m_n, cons, gap_pct, rdy_mode, cyc;

   always #5 clk_buf_i = ~clk_buf_i;

   i_ddr_word_rx #(.WORD_W(W), .SYNC_WORD(SYNC), .LOCK_CNT(LC)) dut (
      .clk_buf_i   (clk_buf_i),
      .reset_n_buf (reset_n_buf),
      .data_i      (data_i),
      .enable_i    (enable_i),
      .realign_i   (realign_i),
      .word_o      (word_o),
      .word_valid_o(word_valid_o),
      .word_ready_i(word_ready_i),
      .locked_o    (locked_o),
      .overflow_o  (overflow_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // W stream bits ending at index e, oldest bit in the MSB.
   function automatic logic [W-1:0] win(input int e);
      logic [W-1:0] w;
      for (int i = 0; i < W; i++) w[i] = (e - i >= 0) ? bits[e-i] : 1'b0;
      return w;
   endfunction

   // Reference: stream pair p = bits 2p (earlier), 2p+1 (later).
   task automatic model_step(input int p);
      logic [W-1:0] w;
      if (m_st == 0) begin
         if (win(2*p+1) == SYNC || win(2*p) == SYNC) begin
            m_off = (win(2*p+1) == SYNC) ? 0 : 1;
            m_m   = 1;
            m_n   = 0;
            m_st  = (LC == 1) ? 2 : 1;
         end
      end else begin
         m_n++;
         if (m_n == W/2) begin
            m_n = 0;
            w   = win(2*p+1-m_off);
            if (m_st == 1) begin
               if (w == SYNC) begin
                  m_m++;
                  if (m_m == LC) m_st = 2;
               end else m_st = 0;
            end else if (!(STRIP && w == SYNC)) exp_q.push_back(w);
         end
      end
   endtask

   task automatic model_hunt();
      m_st = 0; m_m = 0; m_n = 0;
   endtask

   // One clock: b0 presented for the rising edge, b1 for the falling edge.
   task automatic send_pair(input logic b0, input logic b1, input logic en);
      enable_i = en;
      data_i   = b0;
      if (en) begin
         bits.push_back(b0);
         bits.push_back(b1);
         model_step(cons);
         cons++;
      end
      @(posedge clk_buf_i);
      #1 data_i = b1;
      @(negedge clk_buf_i);
      #1;
   endtask

   task automatic put_word(input logic [W-1:0] w);
      for (int i = W-1; i >= 0; i--) txq.push_back(w[i]);
   endtask

   task automatic put_rand(input int n);
      repeat (n) txq.push_back(1'($urandom_range(1)));
   endtask

   task automatic put_zeros(input int n);
      repeat (n) txq.push_back(1'b0);
   endtask

   task automatic flush_tx();
      while (txq.size() >= 2) begin
         if (int'($urandom_range(99)) < gap_pct) send_pair(1'b0, 1'b0, 1'b0);
         else begin
            send_pair(txq[0], txq[1], 1'b1);
            void'(txq.pop_front());
            void'(txq.pop_front());
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) send_pair(1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      reset_n_buf = 1'b0;
      enable_i    = 1'b0;
      realign_i   = 1'b0;
      data_i      = 1'b0;
      repeat (2) @(negedge clk_buf_i);
      #1;
      check("rst_valid", word_valid_o, 0);
      check("rst_word", word_o, 0);
      check("rst_locked", locked_o, 0);
      check("rst_ovf", overflow_o, 0);
      bits.delete();
      txq.delete();
      exp_q.delete();
      // I_DDR holds two zero pairs after reset; they are consumed first.
      repeat (4) bits.push_back(1'b0);
      cons = 0;
      model_hunt();
      reset_n_buf = 1'b1;
   endtask

   // Consumer: ready chosen at the falling edge, so a pop seen here happens at the next rising edge.
   always @(negedge clk_buf_i) begin
      cyc++;
      word_ready_i = (rdy_mode == 1) || (rdy_mode == 2 && (cyc[0] || $urandom_range(1) == 1));
      if (word_valid_o && word_ready_i) begin
         if (exp_q.size() == 0) check("spurious_valid", word_valid_o, 0);
         else check("word", word_o, exp_q.pop_front());
      end
   end

   initial begin
      rdy_mode = 1;
      gap_pct  = 0;

      // Even alignment with delivery latency.
      do_reset();
      repeat (2) put_word(SYNC);
      flush_tx();
      check("even_prelock", locked_o, 0);
      put_word(SYNC);
      put_word(8'h3C);
      flush_tx();
      check("even_locked", locked_o, 1);
      check("even_off", dut.off_q, 0);
      send_pair(1'b0, 1'b0, 1'b1);
      check("lat_c1", word_valid_o, 0);
      send_pair(1'b0, 1'b0, 1'b1);
      check("lat_c2", word_valid_o, 0);
      send_pair(1'b0, 1'b0, 1'b1);
      check("lat_c3", word_valid_o, 1);
      check("lat_word", word_o, 8'h3C);
      idle(6);
      check("even_drain", exp_q.size(), 0);

      // Odd alignment.
      do_reset();
      put_rand(1);
      repeat (3) put_word(SYNC);
      put_word(8'h0F);
      put_rand(1);
      put_zeros(4);
      flush_tx();
      idle(6);
      check("odd_off", dut.off_q, 1);
      check("odd_locked", locked_o, 1);
      check("odd_drain", exp_q.size(), 0);

      // Failed confirm, then a later lock.
      do_reset();
      put_word(SYNC);
      put_word(8'h5A);
      put_zeros(4);
      flush_tx();
      check("fail_locked", locked_o, (m_st == 2));
      check("fail_unlocked", locked_o, 0);
      repeat (3) put_word(SYNC);
      put_word(8'h4B);
      put_zeros(4);
      flush_tx();
      idle(6);
      check("relock", locked_o, 1);
      check("relock_drain", exp_q.size(), 0);

      // Backpressure and overflow.
      do_reset();
      rdy_mode = 0;
      repeat (3) put_word(SYNC);
      put_word(8'h11);
      put_word(8'h22);
      put_word(8'h33);
      put_zeros(4);
      flush_tx();
      idle(4);
      check("bp_valid", word_valid_o, 1);
      check("bp_head", word_o, 8'h11);
      check("bp_ovf", overflow_o, 1);
      check("bp_model", exp_q.size(), 3);
      exp_q.delete(2);
      rdy_mode = 1;
      idle(6);
      check("bp_drain", exp_q.size(), 0);
      check("bp_sticky", overflow_o, 1);

      // Realign flushes the buffer and clears lock and overflow; history is kept.
      do_reset();
      rdy_mode = 0;
      repeat (3) put_word(SYNC);
      put_word(8'h77);
      put_word(8'h11);
      put_word(8'h22);
      put_zeros(4);
      flush_tx();
      idle(3);
      check("ra_locked_pre", locked_o, 1);
      check("ra_ovf_pre", overflow_o, 1);
      realign_i = 1'b1;
      send_pair(1'b0, 1'b0, 1'b0);
      realign_i = 1'b0;
      check("ra_valid", word_valid_o, 0);
      check("ra_locked", locked_o, 0);
      check("ra_ovf", overflow_o, 0);
      exp_q.delete();
      model_hunt();
      rdy_mode = 1;
      repeat (3) put_word(SYNC);
      put_word(8'h77);
      put_word(SYNC);
      put_word(SYNC);
      put_word(8'h88);
      put_zeros(4);
      flush_tx();
      idle(8);
      check("ra_relock", locked_o, 1);
      check("ra_drain", exp_q.size(), 0);

      // Randomized streams with enable gaps and random ready.
      for (int t = 0; t < 8; t++) begin
         do_reset();
         rdy_mode = 2;
         gap_pct  = 25;
         put_rand($urandom_range(9));
         repeat (LC) put_word(SYNC);
         repeat (6) put_word(8'($urandom));
         if (txq.size() % 2 == 1) put_rand(1);
         put_zeros(4);
         flush_tx();
         idle(10);
         check("rnd_drain", exp_q.size(), 0);
         check("rnd_locked", locked_o, (m_st == 2));
         check("rnd_ovf", overflow_o, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
